rr_arb_mux4: RTL
================

Name: rr_arb_mux4

Overview:
Four-input round-robin arbiter with a registered output stage. It sits directly upstream of the codebase's 4:1 mux users: it generates the 2-bit select and applies it to its own 4:1 datapath. It drives the chosen word out with a valid/ready handshake. It turns four independent valid/ready producers into one fair, registered stream, with throughput of 1 word/cycle.

Parameters:
DATAWIDTH, 8, width of each input data word and of out_data

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  4  per-source request; bit i = source i (a=0, b=1, c=2, d=3)
in_ready  output  4  per-source accept; in_valid[i] & in_ready[i] = transfer from source i
in_data_a  input  DATAWIDTH  source 0 data
in_data_b  input  DATAWIDTH  source 1 data
in_data_c  input  DATAWIDTH  source 2 data
in_data_d  input  DATAWIDTH  source 3 data
out_valid  output  1  output register holds a word
out_ready  input  1  downstream accept
out_data  output  DATAWIDTH  registered selected word
out_sel  output  2  registered index of the source that supplied out_data

Behaviour:
- Reset: one clock domain (clk); rst is synchronous, active-high.
- Reset values: out_valid=0, out_data=0, out_sel=0, last-grant pointer ptr=3, so source 0 has top priority after reset.
- load = !out_valid | out_ready. The output register may capture this cycle.
- Arbitration (combinational): search order is ptr+1, ptr+2, ptr+3, ptr (mod 4). The first index with in_valid set is the grant g; any = |in_valid.
- in_ready[i] = load & any & (g==i). At most one bit is set, and never more than one. in_ready depends combinationally on out_ready and in_valid.
- On the edge where load & any: out_data <= data of source g, out_sel <= g, out_valid <= 1, ptr <= g.
- On the edge where load & !any: out_valid <= 0. out_data and out_sel hold their values (don't-care).
- When out_valid & !out_ready: out_data, out_sel, out_valid and ptr all hold. Every in_ready bit is 0.
- Latency: an accepted input appears on out_data in the next cycle. Back-to-back transfers are allowed: drain and load happen on the same edge when out_valid & out_ready & any.
- Fairness: ptr updates only on an accepted transfer. A continuously asserting source waits at most 3 transfers.
- Single requester: the same source may win on consecutive cycles. The rotation does not insert idle cycles.
- Wrap-around: ptr=3 and grant index 3 wrap to 0 modulo 4 in 2-bit arithmetic. No explicit compare is needed.
- Reset mid-operation: a word held in the output register is discarded. No in_ready is asserted in the cycle rst is high.
- in_valid is not required to be sticky. A source that drops valid before being granted is simply skipped.
- Sources must hold in_data stable while in_valid & !in_ready. The block does not check this.

Decomposition:
- Package rr_arb_pkg: localparam N_SRC=4, SEL_W=2, typedef logic [SEL_W-1:0] sel_t, typedef logic [N_SRC-1:0] req_t.
- Sub-module rr_pick4 (purely combinational): inputs req_t req and sel_t ptr; outputs sel_t grant and logic any. It is reused later for wider arbiters.
- The top level holds the ptr register, the output register, the handshake logic and a case-based 4:1 data select on grant.

Test Plan:
- Reset, then in_valid=4'b1111 with data a..d = 8'h10, 8'h20, 8'h30, 8'h40, out_ready=1 -> out_sel sequence 0, 1, 2, 3, 0 on consecutive cycles; out_data 10, 20, 30, 40, 10; out_valid stays 1.
- Only source 2 valid (data 8'hA5), out_ready=1 for 3 cycles -> three transfers with out_sel=2 and out_data=A5; in_ready=4'b0100 each cycle.
- Output full, out_ready=0 for 4 cycles while in_valid=4'b0011 -> out_data and out_sel frozen; in_ready=0. Release out_ready -> next grant follows the rotation from the held ptr.
- Drain with no requests: out_valid=1, out_ready=1, in_valid=0 -> out_valid=0 next cycle; ptr unchanged (next grant with all four valid follows the old ptr).
- ptr=3 (source 3 last granted), in_valid=4'b1001 -> source 0 granted, then source 3. This checks the wrap.
- rst asserted while out_valid=1 and out_ready=0 -> next cycle out_valid=0, out_sel=0, in_ready=0. With all four valid after release, source 0 wins first.

Source files
------------

// File: rtl/rr_arb_pkg.sv
// Shared types and sizes for the round-robin arbiter family.
package rr_arb_pkg;

  localparam int N_SRC = 4;
  localparam int SEL_W = 2;

  typedef logic [SEL_W-1:0] sel_t;
  typedef logic [N_SRC-1:0] req_t;

  // Pointer value that gives source 0 top priority (search starts at ptr+1).
  localparam sel_t PTR_RESET = 2'd3;

endpackage : rr_arb_pkg

// File: rtl/rr_arb_mux4_if.sv
// Handshake bundle between four producers, the arbiter and one consumer.
interface rr_arb_mux4_if #(
  parameter int DATAWIDTH = 8
);
  import rr_arb_pkg::*;

  req_t                 in_valid;
  req_t                 in_ready;
  logic [DATAWIDTH-1:0] in_data_a;
  logic [DATAWIDTH-1:0] in_data_b;
  logic [DATAWIDTH-1:0] in_data_c;
  logic [DATAWIDTH-1:0] in_data_d;
  logic                 out_valid;
  logic                 out_ready;
  logic [DATAWIDTH-1:0] out_data;
  sel_t                 out_sel;

  // Arbiter side.
  modport slave (
    input  in_valid, in_data_a, in_data_b, in_data_c, in_data_d, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );

  // Producer/consumer side.
  modport master (
    output in_valid, in_data_a, in_data_b, in_data_c, in_data_d, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

endinterface : rr_arb_mux4_if

// File: rtl/rr_pick4.sv
// Combinational 4-way round-robin picker: first requester after ptr wins.
module rr_pick4
  import rr_arb_pkg::*;
(
  input  req_t req,
  input  sel_t ptr,
  output sel_t grant,
  output logic any
);

  // Search order ptr+1, ptr+2, ptr+3, ptr; 2-bit adds wrap modulo 4.
  function automatic sel_t pick(input req_t r, input sel_t p);
    sel_t c1;
    sel_t c2;
    sel_t c3;
    sel_t g;
    c1 = p + 2'd1;
    c2 = p + 2'd2;
    c3 = p + 2'd3;
    if (r[c1]) begin
      g = c1;
    end else if (r[c2]) begin
      g = c2;
    end else if (r[c3]) begin
      g = c3;
    end else begin
      g = p;
    end
    return g;
  endfunction

  // Grant index and request-present flag.
  always_comb begin
    grant = pick(req, ptr);
    any   = |req;
  end

endmodule : rr_pick4

// File: rtl/rr_arb_mux4.sv
// Round-robin 4:1 arbiter with a registered output word and valid/ready.
module rr_arb_mux4
  import rr_arb_pkg::*;
#(
  parameter int DATAWIDTH = 8
) (
  input logic           clk,
  input logic           rst,
  rr_arb_mux4_if.slave  bus
);

  sel_t                 r_ptr;
  logic                 r_out_valid;
  logic [DATAWIDTH-1:0] r_out_data;
  sel_t                 r_out_sel;

  sel_t                 w_grant;
  logic                 w_any;
  logic                 w_load;
  logic                 w_fire;
  req_t                 w_in_ready;
  logic [DATAWIDTH-1:0] w_sel_data;

  rr_pick4 u_pick (
    .req   (bus.in_valid),
    .ptr   (r_ptr),
    .grant (w_grant),
    .any   (w_any)
  );

  // Output register can capture when empty or being drained this cycle;
  // reset suppresses any acceptance.
  always_comb begin
    w_load = ~r_out_valid | bus.out_ready;
    w_fire = w_load & w_any & ~rst;
  end

  // One-hot accept to the granted source only.
  always_comb begin
    w_in_ready = 4'b0000;
    if (w_fire) begin
      w_in_ready[w_grant] = 1'b1;
    end else begin
      w_in_ready = 4'b0000;
    end
  end

  // 4:1 data select on the grant.
  always_comb begin
    case (w_grant)
      2'd0:    w_sel_data = bus.in_data_a;
      2'd1:    w_sel_data = bus.in_data_b;
      2'd2:    w_sel_data = bus.in_data_c;
      2'd3:    w_sel_data = bus.in_data_d;
      default: w_sel_data = bus.in_data_a;
    endcase
  end

  // Output register and last-grant pointer; ptr moves only on a transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= 2'd0;
      r_ptr       <= PTR_RESET;
    end else if (w_load) begin
      if (w_any) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_sel_data;
        r_out_sel   <= w_grant;
        r_ptr       <= w_grant;
      end else begin
        r_out_valid <= 1'b0;
      end
    end else begin
      r_out_valid <= r_out_valid;
      r_out_data  <= r_out_data;
      r_out_sel   <= r_out_sel;
      r_ptr       <= r_ptr;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_sel   = r_out_sel;

endmodule : rr_arb_mux4
